// File: rtl/wb_port_arbiter.sv
// Register-file writeback arbiter: the MEM/WB pipe write has priority over the aux port.
// Define WB_ARB_STARVE_GUARD_EN to add the anti-starvation WAIT/FORCE machine.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_regwrite,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        aux_valid,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_src
);

  logic pipe_eff, aux_xfer;

`ifdef WB_ARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] cnt_inc;

  assign stall_pipe = (state == FORCE);
  assign cnt_inc    = wait_cnt + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: if (aux_valid && !aux_ready) begin
          wait_cnt <= 8'd1;
          // A limit of 1 means the first blocked cycle already starves aux.
          state    <= (LIMIT == 8'd1) ? FORCE : WAIT;
        end
        WAIT: if (aux_valid && !aux_ready) begin
          wait_cnt <= cnt_inc;
          if (cnt_inc == LIMIT) state <= FORCE;
        end else begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end
`else
  assign stall_pipe = 1'b0;
`endif

  // In FORCE the pipe request is dropped (upstream is stalled and re-presents it).
  assign pipe_eff  = pipe_valid & pipe_regwrite & (pipe_rd != 5'd0) & ~stall_pipe;
  assign aux_ready = reset & aux_valid & (~pipe_eff | stall_pipe);
  assign aux_xfer  = aux_valid & aux_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
      rf_src   <= 1'b0;
    end else if (pipe_eff) begin
      rf_we    <= 1'b1;
      rf_waddr <= pipe_rd;
      rf_wdata <= pipe_data;
      rf_src   <= 1'b0;
    end else if (aux_xfer && aux_rd != 5'd0) begin
      rf_we    <= 1'b1;
      rf_waddr <= aux_rd;
      rf_wdata <= aux_data;
      rf_src   <= 1'b1;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expectations follow WB_ARB_STARVE_GUARD_EN.
module tb_wb_port_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_regwrite;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_ready, stall_pipe, rf_we, rf_src;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors = 0;
  int miscompares = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_regwrite(pipe_regwrite),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data),
    .aux_ready(aux_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs;
    pipe_valid = 0; pipe_regwrite = 0; pipe_rd = 0; pipe_data = 0;
    aux_valid = 0; aux_rd = 0; aux_data = 0;
  endtask

  task automatic collide;
    pipe_valid = 1; pipe_regwrite = 1; pipe_rd = 5'd3; pipe_data = 32'h33;
    aux_valid = 1; aux_rd = 5'd9; aux_data = 32'h99;
  endtask

  task automatic test_reset;
    reset = 0; idle_inputs(); aux_valid = 1; aux_rd = 5'd2;
    #1;
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== 39'd0) begin
      miscompares++; $display("FAIL reset_rf: got we=%b a=%0d d=%h s=%b want all 0", rf_we, rf_waddr, rf_wdata, rf_src);
    end
    vectors++;
    if (aux_ready !== 1'b0 || stall_pipe !== 1'b0) begin
      miscompares++; $display("FAIL reset_hs: got rdy=%b stall=%b want 0 0", aux_ready, stall_pipe);
    end
    tick(); tick();
    idle_inputs(); reset = 1;
    tick();
  endtask

  task automatic test_pipe_only;
    pipe_valid = 1; pipe_regwrite = 1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      miscompares++; $display("FAIL pipe_only: got we=%b a=%0d d=%h s=%b want 1 5 deadbeef 0", rf_we, rf_waddr, rf_wdata, rf_src);
    end
    tick();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b0, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      miscompares++; $display("FAIL no_write_hold: got we=%b a=%0d d=%h s=%b want 0 5 deadbeef 0", rf_we, rf_waddr, rf_wdata, rf_src);
    end
  endtask

  task automatic test_pipe_rd0_aux;
    pipe_valid = 1; pipe_regwrite = 1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
    aux_valid = 1; aux_rd = 5'd7; aux_data = 32'h12;
    #1;
    vectors++;
    if (aux_ready !== 1'b1) begin
      miscompares++; $display("FAIL rd0_aux_ready: got %b want 1", aux_ready);
    end
    tick();
    idle_inputs();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b1, 5'd7, 32'h12, 1'b1}) begin
      miscompares++; $display("FAIL rd0_aux_write: got we=%b a=%0d d=%h s=%b want 1 7 12 1", rf_we, rf_waddr, rf_wdata, rf_src);
    end
    // regwrite=0 is not an effective pipe write either
    pipe_valid = 1; pipe_regwrite = 0; pipe_rd = 5'd3; aux_valid = 1; aux_rd = 5'd4; aux_data = 32'h44;
    #1;
    vectors++;
    if (aux_ready !== 1'b1) begin
      miscompares++; $display("FAIL nowrite_aux_ready: got %b want 1", aux_ready);
    end
    tick();
    idle_inputs();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b1, 5'd4, 32'h44, 1'b1}) begin
      miscompares++; $display("FAIL nowrite_aux_write: got we=%b a=%0d d=%h s=%b want 1 4 44 1", rf_we, rf_waddr, rf_wdata, rf_src);
    end
  endtask

  task automatic test_aux_rd0;
    aux_valid = 1; aux_rd = 5'd0; aux_data = 32'h55;
    #1;
    vectors++;
    if (aux_ready !== 1'b1) begin
      miscompares++; $display("FAIL aux_rd0_ready: got %b want 1", aux_ready);
    end
    tick();
    idle_inputs();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b0, 5'd4, 32'h44, 1'b1}) begin
      miscompares++; $display("FAIL aux_rd0_write: got we=%b a=%0d d=%h s=%b want 0 4 44 1", rf_we, rf_waddr, rf_wdata, rf_src);
    end
  endtask

  // Runs a collision from IDLE: 4 blocked cycles then a forced grant (guard on),
  // or 20 blocked cycles (guard off).
  task automatic run_collision(input string tag);
    int blocked;
`ifdef WB_ARB_STARVE_GUARD_EN
    blocked = 4;
`else
    blocked = 20;
`endif
    collide();
    for (int i = 0; i < blocked; i++) begin
      #1;
      vectors++;
      if (aux_ready !== 1'b0 || stall_pipe !== 1'b0) begin
        miscompares++; $display("FAIL %s_blocked[%0d]: got rdy=%b stall=%b want 0 0", tag, i, aux_ready, stall_pipe);
      end
      tick();
      vectors++;
      if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
        miscompares++; $display("FAIL %s_pipe_wr[%0d]: got we=%b a=%0d d=%h s=%b want 1 3 33 0", tag, i, rf_we, rf_waddr, rf_wdata, rf_src);
      end
    end
`ifdef WB_ARB_STARVE_GUARD_EN
    #1;
    vectors++;
    if (aux_ready !== 1'b1 || stall_pipe !== 1'b1) begin
      miscompares++; $display("FAIL %s_force: got rdy=%b stall=%b want 1 1", tag, aux_ready, stall_pipe);
    end
    tick();
    aux_valid = 0;
    #1;
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, rf_src} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
      miscompares++; $display("FAIL %s_forced_wr: got we=%b a=%0d d=%h s=%b want 1 9 99 1", tag, rf_we, rf_waddr, rf_wdata, rf_src);
    end
    vectors++;
    if (stall_pipe !== 1'b0) begin
      miscompares++; $display("FAIL %s_back_idle: got stall=%b want 0", tag, stall_pipe);
    end
    tick();
    vectors++;
    if ({rf_we, rf_waddr, rf_src} !== {1'b1, 5'd3, 1'b0}) begin
      miscompares++; $display("FAIL %s_pipe_resume: got we=%b a=%0d s=%b want 1 3 0", tag, rf_we, rf_waddr, rf_src);
    end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_collision;
    run_collision("coll");
  endtask

  task automatic test_wait_abandon;
    // two blocked cycles, aux withdraws, then the count must restart from scratch
    collide();
    tick(); tick();
    aux_valid = 0;
    tick();
    run_collision("abandon");
  endtask

  task automatic test_reset_mid_wait;
    collide();
    tick(); tick();
    reset = 0;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || aux_ready !== 1'b0 || stall_pipe !== 1'b0) begin
      miscompares++; $display("FAIL midwait_reset: got we=%b rdy=%b stall=%b want 0 0 0", rf_we, aux_ready, stall_pipe);
    end
    vectors++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      miscompares++; $display("FAIL midwait_reset_rf: got a=%0d d=%h want 0 0", rf_waddr, rf_wdata);
    end
    tick();
    reset = 1;
    run_collision("post_reset");
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_pipe_rd0_aux();
    test_aux_rd0();
    test_collision();
    test_wait_abandon();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive blocked aux cycles before a forced grant; legal range 1..255.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port pipe_valid, input, 1, the MEM/WB stage holds a valid instruction.
REQ-005 The block SHALL have port pipe_regwrite, input, 1, the MEM/WB instruction writes the register file.
REQ-006 The block SHALL have port pipe_rd, input, 5, the MEM/WB destination register.
REQ-007 The block SHALL have port pipe_data, input, 32, the MEM/WB writeback data.
REQ-008 The block SHALL have port aux_valid, input, 1, a multi-cycle unit requests a register write.
REQ-009 The block SHALL have port aux_rd, input, 5, the aux destination register.
REQ-010 The block SHALL have port aux_data, input, 32, the aux writeback data.
REQ-011 The block SHALL have port aux_ready, output, 1, aux request accepted this cycle (combinational).
REQ-012 The block SHALL have port stall_pipe, output, 1, hold MEM/WB and upstream stages this cycle (combinational from state).
REQ-013 The block SHALL have port rf_we, output, 1, registered register-file write enable.
REQ-014 The block SHALL have port rf_waddr, output, 5, registered write address.
REQ-015 The block SHALL have port rf_wdata, output, 32, registered write data.
REQ-016 The block SHALL have port rf_src, output, 1, registered source of the current write (0 pipe, 1 aux).

Function
REQ-017 A pipe write SHALL be effective when pipe_valid=1, pipe_regwrite=1, pipe_rd!=0 and stall_pipe=0; rd=0 writes are never effective.
REQ-018 aux_ready SHALL be 1 when aux_valid=1 and either no pipe write is effective or the state is FORCE.
REQ-019 An aux transfer SHALL occur when aux_valid=1 and aux_ready=1; aux holds aux_rd/aux_data stable until transfer.
REQ-020 Outputs rf_we/rf_waddr/rf_wdata/rf_src SHALL update one clock after the winning request (latency 1); rf_we=1 only for an effective pipe write or an aux transfer with aux_rd!=0.
REQ-021 With no write in a cycle, rf_we SHALL be 0 and rf_waddr/rf_wdata/rf_src SHALL hold their previous values.
REQ-022 An aux transfer with aux_rd=0 SHALL complete the handshake without asserting rf_we.
REQ-023 The state machine SHALL have states IDLE, WAIT, FORCE with an 8-bit counter wait_cnt.
REQ-024 IDLE -> WAIT when aux_valid=1 and aux_ready=0; wait_cnt loads 1.
REQ-025 In WAIT, aux blocked again: wait_cnt increments; when the incremented value equals STARVE_LIMIT, next state SHALL be FORCE.
REQ-026 In WAIT, aux transfer or aux_valid=0: next state IDLE, wait_cnt cleared.
REQ-027 FORCE SHALL last exactly one cycle: stall_pipe=1, pipe request ignored (upstream re-presents it), aux granted; next state IDLE, wait_cnt cleared, even if aux_valid dropped.
REQ-028 stall_pipe SHALL be 0 in IDLE and WAIT.
REQ-029 Pipe and aux both requesting outside FORCE: pipe SHALL win, aux_ready=0.

Reset
REQ-030 While reset=0, state SHALL be IDLE, wait_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, asynchronously.
REQ-031 Reset asserted mid-WAIT or mid-FORCE SHALL abandon the pending aux request; aux re-presents after reset release.
REQ-032 aux_ready and stall_pipe SHALL be 0 while reset=0.

Configuration
REQ-033 Macro WB_ARB_STARVE_GUARD_EN defined: WAIT/FORCE and stall_pipe behave as REQ-023..REQ-028.
REQ-034 Macro WB_ARB_STARVE_GUARD_EN undefined: no WAIT/FORCE states or wait_cnt, stall_pipe tied 0, aux strictly lower priority (may starve), all other requirements unchanged.

Verification
REQ-035 Pipe only: pipe_valid=1, regwrite=1, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_src=0.
REQ-036 Pipe rd=0, regwrite=1 with aux rd=7 data=0x12 -> aux_ready=1 same cycle; next cycle rf_we=1, rf_waddr=7, rf_src=1.
REQ-037 Collision: pipe rd=3 and aux rd=9 each cycle, STARVE_LIMIT=4, guard on -> aux_ready=0 for 4 cycles, 5th cycle stall_pipe=1 and aux_ready=1, next cycle rf_waddr=9, rf_src=1; then IDLE.
REQ-038 Same as REQ-037 with guard off -> stall_pipe never 1, aux_ready stays 0 for 20 cycles, all writes rf_src=0.
REQ-039 Reset=0 asserted during WAIT (wait_cnt=2) -> rf_we=0, state IDLE immediately; after release aux blocked again, counting restarts at 1.
REQ-040 Aux rd=0, no pipe request -> aux_ready=1, next cycle rf_we=0.
